// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad scanner.
//   kp_state_e  : one-hot scanner state encoding
//   row_class_e : classification of a sampled row vector
//   row_info_t  : class plus the index of a set bit
//   clog2       : ceiling log2, usable in parameter expressions
//   bit_index   : index of the highest set bit (0 when none is set)
//   classify    : zero / single / multi classification of a vector
package keypad_pkg;

  typedef enum logic [3:0] {
    SCAN     = 4'b0001,
    DEBOUNCE = 4'b0010,
    HELD     = 4'b0100,
    RELEASE  = 4'b1000
  } kp_state_e;

  typedef enum logic [1:0] {
    ROW_ZERO,
    ROW_SINGLE,
    ROW_MULTI
  } row_class_e;

  typedef struct packed {
    row_class_e  cls;
    logic [7:0]  idx;
  } row_info_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  function automatic logic [7:0] bit_index(input logic [31:0] v);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  function automatic row_info_t classify(input logic [31:0] v);
    row_info_t ri;
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    ri.idx = bit_index(v);
    if (n == 0)      ri.cls = ROW_ZERO;
    else if (n == 1) ri.cls = ROW_SINGLE;
    else             ri.cls = ROW_MULTI;
    return ri;
  endfunction

endpackage

// File: rtl/keypad_scan_n_if.sv
// Keypad pin / event bundle between the scanner and the application side.
//   row         : row sense from the pins (active-high)
//   col         : one-hot column drive
//   key_code    : linear index of the last accepted key
//   key_valid   : a debounced key is held
//   key_press   : 1-cycle pulse on press and on each auto-repeat
//   key_release : 1-cycle pulse on accepted release
//   multi_key   : 1-cycle pulse when a sample shows several rows
// Modports: master = scanner, slave = pins/application side.
interface keypad_scan_n_if
  import keypad_pkg::*;
#(
  parameter int N_ROW = 4,
  parameter int N_COL = 4,
  parameter int KEY_W = clog2(N_ROW * N_COL)
);
  logic [N_ROW-1:0] row;
  logic [N_COL-1:0] col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_press;
  logic             key_release;
  logic             multi_key;

  modport master (
    input  row,
    output col, key_code, key_valid, key_press, key_release, multi_key
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_press, key_release, multi_key
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clock tick every 2^SCAN_DIV_BITS
// clocks (tick is high while the divider is all-ones).
//   clk, reset_p : clock, asynchronous active-high reset
//   tick         : single-cycle scan strobe
module scan_tick_gen #(
  parameter int SCAN_DIV_BITS = 20
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);
  logic [SCAN_DIV_BITS-1:0] div;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) div <= '0;
    else         div <= div + SCAN_DIV_BITS'(1);
  end

  assign tick = &div;
endmodule

// File: rtl/keypad_scan_n.sv
// Matrix-keypad scanner: one-hot column drive, debounced press/release,
// multi-key rejection and optional auto-repeat. All decisions are taken
// on scan ticks; outputs are registered.
//   clk, reset_p : clock, asynchronous active-high reset
//   bus          : keypad_scan_n_if.master (row in; col, key_code,
//                  key_valid, key_press, key_release, multi_key out)
module keypad_scan_n
  import keypad_pkg::*;
#(
  parameter int N_ROW         = 4,
  parameter int N_COL         = 4,
  parameter int SCAN_DIV_BITS = 20,
  parameter int DEBOUNCE_CNT  = 3,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_RATE   = 4
) (
  input  logic            clk,
  input  logic            reset_p,
  keypad_scan_n_if.master bus
);
  localparam int KEY_W = clog2(N_ROW * N_COL);
  localparam int CNT_W = clog2(DEBOUNCE_CNT + 1);
  localparam int REP_W = clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  kp_state_e        state, state_n;
  logic [N_COL-1:0] col, col_n, col_rot;
  logic [N_ROW-1:0] lat_row, lat_row_n;
  logic [KEY_W-1:0] key_code, key_code_n, cand_code, cand_code_n, row_code;
  logic             key_valid, key_valid_n;
  logic             key_press, key_press_n;
  logic             key_release, key_release_n;
  logic             multi_key, multi_key_n;
  logic [CNT_W-1:0] deb, deb_n, rel, rel_n;
  logic [REP_W-1:0] rep, rep_n;
  logic             tick, do_accept, do_release;
  row_info_t        row_info;
  logic [7:0]       col_idx;

  scan_tick_gen #(.SCAN_DIV_BITS(SCAN_DIV_BITS)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (tick)
  );

  assign col_rot  = (col << 1) | (col >> (N_COL - 1));
  assign row_info = classify(32'(bus.row));
  assign col_idx  = bit_index(32'(col));
  assign row_code = KEY_W'(int'(col_idx) * N_ROW + int'(row_info.idx));

  always_comb begin
    state_n       = state;
    col_n         = col;
    lat_row_n     = lat_row;
    key_code_n    = key_code;
    cand_code_n   = cand_code;
    key_valid_n   = key_valid;
    key_press_n   = 1'b0;
    key_release_n = 1'b0;
    multi_key_n   = 1'b0;
    deb_n         = deb;
    rel_n         = rel;
    rep_n         = rep;
    do_accept     = 1'b0;
    do_release    = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          unique case (row_info.cls)
            ROW_ZERO:  col_n = col_rot;
            ROW_MULTI: begin
              col_n       = col_rot;
              multi_key_n = 1'b1;
            end
            default: begin
              lat_row_n   = bus.row;
              cand_code_n = row_code;
              deb_n       = CNT_W'(1);
              if (DEBOUNCE_CNT == 1) do_accept = 1'b1;
              else                   state_n   = DEBOUNCE;
            end
          endcase
        end
        DEBOUNCE: begin
          if (bus.row == lat_row) begin
            deb_n = deb + CNT_W'(1);
            if (deb_n >= CNT_W'(DEBOUNCE_CNT)) do_accept = 1'b1;
          end else begin
            state_n = SCAN;
            col_n   = col_rot;
          end
        end
        HELD: begin
          if (bus.row != '0) begin
            // A changed pattern keeps the original key; only repeat runs.
            // After each repeat the counter reloads to REPEAT_DELAY so the
            // next pulse lands REPEAT_RATE ticks later.
            if (REPEAT_DELAY > 0) begin
              rep_n = rep + REP_W'(1);
              if (rep_n == REP_W'(REPEAT_DELAY) ||
                  rep_n == REP_W'(REPEAT_DELAY + REPEAT_RATE)) begin
                key_press_n = 1'b1;
                rep_n       = REP_W'(REPEAT_DELAY);
              end
            end
          end else begin
            state_n = RELEASE;
            rel_n   = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) do_release = 1'b1;
          end
        end
        RELEASE: begin
          if (bus.row == '0) begin
            rel_n = rel + CNT_W'(1);
            if (rel_n >= CNT_W'(DEBOUNCE_CNT)) do_release = 1'b1;
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase

      if (do_accept) begin
        state_n     = HELD;
        key_code_n  = cand_code_n;
        key_valid_n = 1'b1;
        key_press_n = 1'b1;
        rep_n       = '0;
      end
      if (do_release) begin
        state_n       = SCAN;
        key_valid_n   = 1'b0;
        key_release_n = 1'b1;
        col_n         = col_rot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= SCAN;
      col         <= N_COL'(1);
      lat_row     <= '0;
      key_code    <= '0;
      cand_code   <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
      deb         <= '0;
      rel         <= '0;
      rep         <= '0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      lat_row     <= lat_row_n;
      key_code    <= key_code_n;
      cand_code   <= cand_code_n;
      key_valid   <= key_valid_n;
      key_press   <= key_press_n;
      key_release <= key_release_n;
      multi_key   <= multi_key_n;
      deb         <= deb_n;
      rel         <= rel_n;
      rep         <= rep_n;
    end
  end

  assign bus.col         = col;
  assign bus.key_code    = key_code;
  assign bus.key_valid   = key_valid;
  assign bus.key_press   = key_press;
  assign bus.key_release = key_release;
  assign bus.multi_key   = multi_key;
endmodule

// File: tb/tb_keypad_scan_n.sv
// Scoreboard bench for keypad_scan_n: stimulus holds a row value for one
// full scan period, a reference model predicts pulses and status, and a
// monitor compares whatever the DUT presents against the queued results.
module tb_keypad_scan_n;
  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int DIV = 4;
  localparam int PER = 16;
  localparam int DB  = 3;
  localparam int RD  = 4;
  localparam int RR  = 2;

  localparam int EV_PRESS   = 1;
  localparam int EV_RELEASE = 2;
  localparam int EV_MULTI   = 4;

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  keypad_scan_n_if #(.N_ROW(NR), .N_COL(NC)) bus ();

  keypad_scan_n #(
    .N_ROW(NR), .N_COL(NC), .SCAN_DIV_BITS(DIV),
    .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  typedef struct { int kind; int code; int tick; } ev_t;
  typedef struct { int col; int valid; int code; int tick; } st_t;
  ev_t ev_q[$];
  st_t st_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keypad behaviour per scan sample.
  int m_col, m_valid, m_code, cand_pat, cand_code, cand_run;
  int rel_run, held_ticks, stim_tick;

  task automatic model_reset();
    m_col = 0; m_valid = 0; m_code = 0; cand_pat = 0; cand_code = 0;
    cand_run = 0; rel_run = 0; held_ticks = 0; stim_tick = 0;
  endtask

  function automatic int low_bit(input int r);
    for (int i = 0; i < 32; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_accept();
    m_valid = 1; m_code = cand_code; cand_run = 0; held_ticks = 0; rel_run = 0;
    ev_q.push_back('{kind: EV_PRESS, code: m_code, tick: stim_tick});
  endtask

  task automatic model_tick(input int r);
    stim_tick++;
    if (m_valid == 0) begin
      if (cand_run > 0) begin
        if (r == cand_pat) begin
          cand_run++;
          if (cand_run == DB) model_accept();
        end else begin
          cand_run = 0;
          m_col = (m_col + 1) % NC;
        end
      end else if ($countones(r) == 0) begin
        m_col = (m_col + 1) % NC;
      end else if ($countones(r) > 1) begin
        m_col = (m_col + 1) % NC;
        ev_q.push_back('{kind: EV_MULTI, code: m_code, tick: stim_tick});
      end else begin
        cand_pat  = r;
        cand_code = m_col * NR + low_bit(r);
        cand_run  = 1;
        if (DB == 1) model_accept();
      end
    end else if (r != 0) begin
      if (rel_run > 0) rel_run = 0;
      else begin
        held_ticks++;
        if (RD > 0 && held_ticks >= RD && (held_ticks - RD) % RR == 0)
          ev_q.push_back('{kind: EV_PRESS, code: m_code, tick: stim_tick});
      end
    end else begin
      rel_run++;
      if (rel_run == DB) begin
        m_valid = 0; rel_run = 0; m_col = (m_col + 1) % NC;
        ev_q.push_back('{kind: EV_RELEASE, code: m_code, tick: stim_tick});
      end
    end
    st_q.push_back('{col: 1 << m_col, valid: m_valid, code: m_code, tick: stim_tick});
  endtask

  // Called at a negedge; returns at the negedge after the tick edge.
  task automatic step(input int r);
    bus.row = NR'(r);
    model_tick(r);
    repeat (PER) @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor
  int edges;
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) edges <= 0;
    else         edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (!reset_p) begin
      int mask;
      mask = (bus.key_press ? EV_PRESS : 0) | (bus.key_release ? EV_RELEASE : 0) |
             (bus.multi_key ? EV_MULTI : 0);
      if (mask != 0) begin
        if (ev_q.size() == 0) chk("unexpected_pulse", mask, 0);
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("pulse_kind", mask, e.kind);
          chk("pulse_code", int'(bus.key_code), e.code);
          chk("pulse_tick", edges / PER, e.tick);
          chk("pulse_phase", edges % PER, 0);
        end
      end
      if (edges > 0 && edges % PER == 0) begin
        if (st_q.size() == 0) chk("status_missing", 1, 0);
        else begin
          st_t s;
          s = st_q.pop_front();
          chk("col", int'(bus.col), s.col);
          chk("key_valid", int'(bus.key_valid), s.valid);
          chk("key_code", int'(bus.key_code), s.code);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"}, int'(bus.col), 1);
    chk({tag, "_valid"}, int'(bus.key_valid), 0);
    chk({tag, "_code"}, int'(bus.key_code), 0);
    chk({tag, "_pulses"}, int'({bus.key_press, bus.key_release, bus.multi_key}), 0);
  endtask

  function automatic int rand_row();
    int k, a, b;
    k = int'($urandom_range(0, 9));
    if (k < 4) return 0;
    a = int'($urandom_range(0, NR - 1));
    if (k < 8) return 1 << a;
    b = (a + 1 + int'($urandom_range(0, NR - 2))) % NR;
    return (1 << a) | (1 << b);
  endfunction

  initial begin
    bus.row = '0;
    reset_p = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    reset_p = 1'b0;

    // Column rotation with no key, then press code 10 at col 0100.
    step(0); step(0);
    chk("rot_col", int'(bus.col), 4'b0100);
    step(4); step(4); step(4);
    chk("press_code", int'(bus.key_code), 10);
    chk("press_valid", int'(bus.key_valid), 1);
    chk("press_col", int'(bus.col), 4'b0100);
    // Release.
    step(0); step(0); step(0);
    chk("rel_valid", int'(bus.key_valid), 0);
    chk("rel_code", int'(bus.key_code), 10);
    chk("rel_col", int'(bus.col), 4'b1000);
    // Bounce shorter than debounce.
    step(0); step(0); step(0); step(4); step(0);
    chk("bounce_col", int'(bus.col), 4'b1000);
    chk("bounce_valid", int'(bus.key_valid), 0);
    // Multi-key.
    step(0); step(3);
    chk("multi_col", int'(bus.col), 4'b0010);
    // Release bounce returns to held.
    step(1); step(1); step(1); step(0); step(1); step(1);
    chk("relbounce_valid", int'(bus.key_valid), 1);
    chk("relbounce_code", int'(bus.key_code), 4);
    step(0); step(0); step(0);
    // Auto-repeat, then reset while held.
    step(4); step(4); step(4);
    for (int i = 0; i < 12; i++) step(4);
    #2;
    chk("events_drained", ev_q.size(), 0);
    reset_p = 1'b1;
    #1 chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1 chk("midreset_no_release", int'(bus.key_release), 0);
    chk("status_drained", st_q.size(), 0);
    ev_q.delete();
    st_q.delete();
    model_reset();
    @(negedge clk);
    reset_p = 1'b0;

    // Randomized segments.
    for (int s = 0; s < 70; s++) begin
      int r, len;
      r   = rand_row();
      len = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) step(r);
    end
    #2;
    chk("final_events_drained", ev_q.size(), 0);
    chk("final_status_drained", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
